// File: rtl/bids22_ctrl_driver_pkg.sv
// Shared types for the bids22 controller-side driver: engine opcodes, engine
// error codes, driver completion status and FSM states.
package bids22defs;

    typedef enum logic [3:0] {
        NO_OP        = 4'd0,
        UNLOCK       = 4'd1,
        LOCK         = 4'd2,
        LOADX        = 4'd3,
        LOADY        = 4'd4,
        LOADZ        = 4'd5,
        SETMASK      = 4'd6,
        SETTIMER     = 4'd7,
        SETBIDCHARGE = 4'd8
    } op_t;

    typedef enum logic [3:0] {
        NOERROR   = 4'd0,
        BADKEY    = 4'd1,
        LOCKED    = 4'd2,
        NOTLOCKED = 4'd3
    } cerr_t;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        DUT_ERR = 2'd1,
        TIMEOUT = 2'd2
    } drv_status_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        GAP      = 3'd2,
        START    = 3'd3,
        WAITOVER = 3'd4,
        FINISH   = 3'd5
    } drv_state_t;

    // Index of the final LOCK in the op list; the list is one shorter without UNLOCK.
    function automatic logic [2:0] last_idx(input logic with_unlock);
        return with_unlock ? 3'd7 : 3'd6;
    endfunction

    function automatic logic [7:0] len_m1(input logic [7:0] len);
        return (len == 8'd0) ? 8'd0 : len - 8'd1;
    endfunction

endpackage

// File: rtl/bids22_ctrl_driver_op_rom.sv
// Maps an op-list index to the {op, data} pair to drive, skipping UNLOCK
// when the engine was not locked at request time.
module bids22_op_rom
    import bids22defs::*;
#(
    parameter int DATAWIDTH  = 32,
    parameter int NUMBIDDERS = 3
) (
    input  logic [2:0]            idx,
    input  logic                  with_unlock,
    input  logic [DATAWIDTH-1:0]  key,
    input  logic [DATAWIDTH-1:0]  x_val,
    input  logic [DATAWIDTH-1:0]  y_val,
    input  logic [DATAWIDTH-1:0]  z_val,
    input  logic [DATAWIDTH-1:0]  timer_val,
    input  logic [DATAWIDTH-1:0]  charge_val,
    input  logic [NUMBIDDERS-1:0] mask_val,
    output op_t                   op,
    output logic [DATAWIDTH-1:0]  data
);

    logic [2:0] slot;

    always_comb begin
        slot = with_unlock ? idx : idx + 3'd1;
        op   = NO_OP;
        data = '0;
        case (slot)
            3'd0: begin op = UNLOCK;       data = key;        end
            3'd1: begin op = LOADX;        data = x_val;      end
            3'd2: begin op = LOADY;        data = y_val;      end
            3'd3: begin op = LOADZ;        data = z_val;      end
            3'd4: begin op = SETMASK;      data[NUMBIDDERS-1:0] = mask_val; end
            3'd5: begin op = SETTIMER;     data = timer_val;  end
            3'd6: begin op = SETBIDCHARGE; data = charge_val; end
            default: begin op = LOCK;      data = key;        end
        endcase
    end

endmodule

// File: rtl/bids22_ctrl_driver.sv
// Turns one host request into the bids22 engine command stream (optional
// unlock, config loads, lock, timed round) and reports the round result.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for go
// ISSUE    | op on C_op (error window), or NO_OP while stalled on c_ready
// GAP      | one NO_OP cycle after an op, still inside its error window
// START    | C_start high for round_len cycles
// WAITOVER | waiting for c_roundOver, bounded by ROUND_TIMEOUT
// FINISH   | done pulse, then back to IDLE
module bids22_ctrl_driver
    import bids22defs::*;
#(
    parameter int DATAWIDTH     = 32,
    parameter int NUMBIDDERS    = 3,
    parameter int ROUND_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  cfg_en,
    input  logic [DATAWIDTH-1:0]  key,
    input  logic [DATAWIDTH-1:0]  x_val,
    input  logic [DATAWIDTH-1:0]  y_val,
    input  logic [DATAWIDTH-1:0]  z_val,
    input  logic [DATAWIDTH-1:0]  timer_val,
    input  logic [DATAWIDTH-1:0]  charge_val,
    input  logic [NUMBIDDERS-1:0] mask_val,
    input  logic [7:0]            round_len,
    output logic [3:0]            C_op,
    output logic [DATAWIDTH-1:0]  C_data,
    output logic                  C_start,
    input  logic                  c_ready,
    input  logic [3:0]            c_err,
    input  logic                  c_roundOver,
    input  logic [DATAWIDTH-1:0]  c_maxBid,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            status,
    output logic [3:0]            err_code,
    output logic [DATAWIDTH-1:0]  max_bid
);

    localparam int CW = 16;

    drv_state_t state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic locked_q, locked_d;
    logic with_unlock_q;

    logic [DATAWIDTH-1:0]  key_q, x_q, y_q, z_q, timer_q, charge_q;
    logic [NUMBIDDERS-1:0] mask_q;
    logic [7:0]            round_len_q;

    logic [3:0]           c_op_d;
    logic [DATAWIDTH-1:0] c_data_d, max_bid_d;
    logic                 c_start_d, busy_d, done_d;
    logic [1:0]           status_d;
    logic [3:0]           err_d;

    logic                 idle;
    logic [2:0]           rom_idx;
    logic                 rom_unlock;
    op_t                  rom_op;
    logic [DATAWIDTH-1:0] rom_data;

    // In IDLE the ROM sees the live inputs so the first op can leave on the accept edge.
    assign idle       = (state_q == IDLE);
    assign rom_idx    = idle ? 3'd0 : (state_q == GAP) ? idx_q + 3'd1 : idx_q;
    assign rom_unlock = idle ? locked_q : with_unlock_q;

    bids22_op_rom #(
        .DATAWIDTH  (DATAWIDTH),
        .NUMBIDDERS (NUMBIDDERS)
    ) u_rom (
        .idx         (rom_idx),
        .with_unlock (rom_unlock),
        .key         (idle ? key        : key_q),
        .x_val       (idle ? x_val      : x_q),
        .y_val       (idle ? y_val      : y_q),
        .z_val       (idle ? z_val      : z_q),
        .timer_val   (idle ? timer_val  : timer_q),
        .charge_val  (idle ? charge_val : charge_q),
        .mask_val    (idle ? mask_val   : mask_q),
        .op          (rom_op),
        .data        (rom_data)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        locked_d  = locked_q;
        c_op_d    = NO_OP;
        c_data_d  = '0;
        c_start_d = 1'b0;
        busy_d    = busy;
        done_d    = 1'b0;
        status_d  = status;
        err_d     = err_code;
        max_bid_d = max_bid;
        case (state_q)
            IDLE: begin
                if (go) begin
                    busy_d   = 1'b1;
                    status_d = OK;
                    err_d    = '0;
                    idx_d    = '0;
                    if (cfg_en) begin
                        state_d = ISSUE;
                        if (c_ready) begin
                            c_op_d   = rom_op;
                            c_data_d = rom_data;
                        end
                    end else if (locked_q) begin
                        state_d   = START;
                        c_start_d = 1'b1;
                        cnt_d     = CW'(len_m1(round_len));
                    end else begin
                        state_d  = FINISH;
                        done_d   = 1'b1;
                        status_d = DUT_ERR;
                    end
                end
            end
            ISSUE: begin
                if (C_op != NO_OP) begin
                    if (c_err != NOERROR) begin
                        state_d  = FINISH;
                        done_d   = 1'b1;
                        status_d = DUT_ERR;
                        err_d    = c_err;
                    end else begin
                        state_d = GAP;
                    end
                end else if (c_ready) begin
                    c_op_d   = rom_op;
                    c_data_d = rom_data;
                end
            end
            GAP: begin
                if (c_err != NOERROR) begin
                    state_d  = FINISH;
                    done_d   = 1'b1;
                    status_d = DUT_ERR;
                    err_d    = c_err;
                end else begin
                    if (with_unlock_q && idx_q == 3'd0)
                        locked_d = 1'b0;
                    if (idx_q == last_idx(with_unlock_q)) begin
                        locked_d  = 1'b1;
                        state_d   = START;
                        c_start_d = 1'b1;
                        cnt_d     = CW'(len_m1(round_len_q));
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ISSUE;
                        if (c_ready) begin
                            c_op_d   = rom_op;
                            c_data_d = rom_data;
                        end
                    end
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    state_d = WAITOVER;
                    cnt_d   = CW'(ROUND_TIMEOUT - 1);
                end else begin
                    c_start_d = 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                end
            end
            WAITOVER: begin
                if (c_roundOver) begin
                    state_d   = FINISH;
                    done_d    = 1'b1;
                    status_d  = OK;
                    max_bid_d = c_maxBid;
                end else if (cnt_q == '0) begin
                    state_d  = FINISH;
                    done_d   = 1'b1;
                    status_d = TIMEOUT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            C_op     <= NO_OP;
            C_data   <= '0;
            C_start  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            status   <= OK;
            err_code <= '0;
            max_bid  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            C_op     <= c_op_d;
            C_data   <= c_data_d;
            C_start  <= c_start_d;
            busy     <= busy_d;
            done     <= done_d;
            status   <= status_d;
            err_code <= err_d;
            max_bid  <= max_bid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            with_unlock_q <= 1'b0;
            key_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            z_q           <= '0;
            timer_q       <= '0;
            charge_q      <= '0;
            mask_q        <= '0;
            round_len_q   <= '0;
        end else if (idle && go) begin
            with_unlock_q <= locked_q;
            key_q         <= key;
            x_q           <= x_val;
            y_q           <= y_val;
            z_q           <= z_val;
            timer_q       <= timer_val;
            charge_q      <= charge_val;
            mask_q        <= mask_val;
            round_len_q   <= round_len;
        end
    end

endmodule

// File: tb/tb_bids22_ctrl_driver.sv
// Directed bench for bids22_ctrl_driver with a small reactive engine stub.
module tb_bids22_ctrl_driver;

    localparam logic [3:0] E_BADKEY = 4'd1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        cfg_en = 1'b0;
    logic [31:0] key = '0, x_val = '0, y_val = '0, z_val = '0, timer_val = '0, charge_val = '0;
    logic [2:0]  mask_val = '0;
    logic [7:0]  round_len = '0;
    logic [3:0]  C_op;
    logic [31:0] C_data;
    logic        C_start;
    logic        c_ready = 1'b1;
    logic [3:0]  c_err = '0;
    logic        c_roundOver = 1'b0;
    logic [31:0] c_maxBid = '0;
    logic        busy, done;
    logic [1:0]  status;
    logic [3:0]  err_code;
    logic [31:0] max_bid;

    int checks = 0;
    int failures = 0;

    logic [3:0]  log_op [16];
    logic [31:0] log_data [16];
    int          log_cyc [16];
    int n_ops, start_cnt, rise_cyc, fall_cyc, done_cyc;
    logic [1:0]  d_status, status_after;
    logic [3:0]  d_err;
    logic [31:0] d_max;
    logic        busy1, busy_after;

    logic [3:0]  err_op, stall_op;
    int          rover_delay, go_again_cyc;
    logic [31:0] maxbid_stub;

    bids22_ctrl_driver dut (
        .clk(clk), .reset(reset), .go(go), .cfg_en(cfg_en), .key(key),
        .x_val(x_val), .y_val(y_val), .z_val(z_val), .timer_val(timer_val),
        .charge_val(charge_val), .mask_val(mask_val), .round_len(round_len),
        .C_op(C_op), .C_data(C_data), .C_start(C_start), .c_ready(c_ready),
        .c_err(c_err), .c_roundOver(c_roundOver), .c_maxBid(c_maxBid),
        .busy(busy), .done(done), .status(status), .err_code(err_code), .max_bid(max_bid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic c, input logic [31:0] k, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] z, input logic [2:0] m,
                           input logic [31:0] t, input logic [31:0] ch, input logic [7:0] rl);
        cfg_en = c; key = k; x_val = x; y_val = y; z_val = z;
        mask_val = m; timer_val = t; charge_val = ch; round_len = rl;
    endtask

    task automatic stub(input logic [3:0] eo, input logic [3:0] so, input int rd,
                        input logic [31:0] mb, input int ga);
        err_op = eo; stall_op = so; rover_delay = rd; maxbid_stub = mb; go_again_cyc = ga;
    endtask

    // Pulses go, then plays the engine for up to max_cyc cycles, logging what the DUT drives.
    task automatic run_req(input int max_cyc);
        logic       prev_start;
        logic [3:0] prev_op;
        int         stall_from, stall_to;
        n_ops = 0; start_cnt = 0; rise_cyc = -1; fall_cyc = -1; done_cyc = -1;
        for (int i = 0; i < 16; i++) begin
            log_op[i] = '0; log_data[i] = '0; log_cyc[i] = -1;
        end
        prev_start = 1'b0; prev_op = '0; stall_from = -1; stall_to = -1;
        c_maxBid = maxbid_stub;
        go = 1'b1;
        tick();
        go = 1'b0;
        busy1 = busy;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            if (C_op !== 4'd0 && n_ops < 16) begin
                log_op[n_ops] = C_op; log_data[n_ops] = C_data; log_cyc[n_ops] = cyc;
                n_ops++;
            end
            if (C_start === 1'b1) begin
                start_cnt++;
                if (!prev_start) rise_cyc = cyc;
            end
            if (C_start === 1'b0 && prev_start) fall_cyc = cyc;
            if (done === 1'b1) begin
                done_cyc = cyc; d_status = status; d_err = err_code; d_max = max_bid;
                break;
            end
            if (stall_op != 4'd0 && C_op === stall_op) begin
                stall_from = cyc; stall_to = cyc + 5;
            end
            c_ready     = !(cyc > stall_from && cyc <= stall_to);
            c_err       = (err_op != 4'd0 && prev_op === err_op) ? E_BADKEY : 4'd0;
            c_roundOver = (rover_delay >= 0 && fall_cyc >= 0 && cyc == fall_cyc + rover_delay);
            if (cyc == go_again_cyc) begin
                go = 1'b1; cfg_en = 1'b0; z_val = 32'd999;
            end else begin
                go = 1'b0;
            end
            prev_start = C_start;
            prev_op = C_op;
            tick();
        end
        c_ready = 1'b1; c_err = '0; c_roundOver = 1'b0; go = 1'b0;
        tick();
        busy_after = busy;
        status_after = status;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (C_op !== 4'd0 || C_data !== 32'd0 || C_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_cmd: got op=%0d data=%0d start=%0b want 0 0 0", C_op, C_data, C_start);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: got busy=%0b done=%0b want 0 0", busy, done);
        end
        checks++;
        if (status !== 2'd0 || err_code !== 4'd0 || max_bid !== 32'd0) begin
            failures++;
            $display("FAIL reset_res: got status=%0d err=%0d max=%0d want 0 0 0", status, err_code, max_bid);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_first_config();
        logic [3:0]  eop [7] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
        logic [31:0] edat [7] = '{32'd100, 32'd200, 32'd50, 32'd5, 32'd4, 32'd2, 32'hA5};
        set_req(1'b1, 32'hA5, 32'd100, 32'd200, 32'd50, 3'b101, 32'd4, 32'd2, 8'd3);
        stub(4'd0, 4'd0, 2, 32'd40, -1);
        run_req(60);
        checks++;
        if (busy1 !== 1'b1) begin failures++; $display("FAIL first_busy: got %0b want 1", busy1); end
        checks++;
        if (n_ops != 7) begin failures++; $display("FAIL first_nops: got %0d want 7", n_ops); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (log_op[i] !== eop[i] || log_data[i] !== edat[i] || log_cyc[i] != 1 + 2 * i) begin
                failures++;
                $display("FAIL first_op%0d: got op=%0d data=%0d cyc=%0d want op=%0d data=%0d cyc=%0d",
                         i, log_op[i], log_data[i], log_cyc[i], eop[i], edat[i], 1 + 2 * i);
            end
        end
        checks++;
        if (rise_cyc != 15 || start_cnt != 3) begin
            failures++;
            $display("FAIL first_start: got rise=%0d len=%0d want 15 3", rise_cyc, start_cnt);
        end
        checks++;
        if (done_cyc != 21 || d_status !== 2'd0 || d_max !== 32'd40) begin
            failures++;
            $display("FAIL first_done: got cyc=%0d status=%0d max=%0d want 21 0 40", done_cyc, d_status, d_max);
        end
        checks++;
        if (busy_after !== 1'b0) begin failures++; $display("FAIL first_busyfall: got %0b want 0", busy_after); end
    endtask

    task automatic test_relock_config();
        logic [3:0]  eop [8] = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
        logic [31:0] edat [8] = '{32'hA5, 32'd11, 32'd22, 32'd33, 32'd3, 32'd5, 32'd6, 32'hA5};
        set_req(1'b1, 32'hA5, 32'd11, 32'd22, 32'd33, 3'b011, 32'd5, 32'd6, 8'd2);
        stub(4'd0, 4'd0, 2, 32'd77, 4);
        run_req(60);
        checks++;
        if (n_ops != 8) begin failures++; $display("FAIL relock_nops: got %0d want 8", n_ops); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_op[i] !== eop[i] || log_data[i] !== edat[i] || log_cyc[i] != 1 + 2 * i) begin
                failures++;
                $display("FAIL relock_op%0d: got op=%0d data=%0d cyc=%0d want op=%0d data=%0d cyc=%0d",
                         i, log_op[i], log_data[i], log_cyc[i], eop[i], edat[i], 1 + 2 * i);
            end
        end
        checks++;
        if (rise_cyc != 17 || start_cnt != 2 || done_cyc != 22 || d_status !== 2'd0 || d_max !== 32'd77) begin
            failures++;
            $display("FAIL relock_round: got rise=%0d len=%0d done=%0d status=%0d max=%0d want 17 2 22 0 77",
                     rise_cyc, start_cnt, done_cyc, d_status, d_max);
        end
    endtask

    task automatic test_badkey();
        set_req(1'b1, 32'hA5, 32'd1, 32'd2, 32'd3, 3'b001, 32'd1, 32'd1, 8'd2);
        stub(4'd1, 4'd0, 2, 32'd0, -1);
        run_req(40);
        checks++;
        if (n_ops != 1 || log_op[0] !== 4'd1 || log_data[0] !== 32'hA5) begin
            failures++;
            $display("FAIL badkey_ops: got n=%0d op0=%0d data0=%0h want 1 1 a5", n_ops, log_op[0], log_data[0]);
        end
        checks++;
        if (done_cyc != 3 || d_status !== 2'd1 || d_err !== E_BADKEY) begin
            failures++;
            $display("FAIL badkey_done: got cyc=%0d status=%0d err=%0d want 3 1 %0d", done_cyc, d_status, d_err, E_BADKEY);
        end
        checks++;
        if (start_cnt != 0) begin failures++; $display("FAIL badkey_start: got %0d want 0", start_cnt); end
        checks++;
        if (status_after !== 2'd1) begin failures++; $display("FAIL badkey_hold: got %0d want 1", status_after); end
    endtask

    task automatic test_ready_stall();
        int ecyc [8] = '{1, 3, 10, 12, 14, 16, 18, 20};
        set_req(1'b1, 32'hA5, 32'd7, 32'd8, 32'd9, 3'b111, 32'd3, 32'd1, 8'd0);
        stub(4'd0, 4'd3, 2, 32'd55, -1);
        run_req(60);
        checks++;
        if (n_ops != 8 || log_op[0] !== 4'd1 || log_op[2] !== 4'd4 || log_op[7] !== 4'd2) begin
            failures++;
            $display("FAIL stall_ops: got n=%0d op0=%0d op2=%0d op7=%0d want 8 1 4 2", n_ops, log_op[0], log_op[2], log_op[7]);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_cyc[i] != ecyc[i]) begin
                failures++;
                $display("FAIL stall_cyc%0d: got %0d want %0d", i, log_cyc[i], ecyc[i]);
            end
        end
        checks++;
        if (rise_cyc != 22 || start_cnt != 1 || done_cyc != 26 || d_status !== 2'd0 || d_max !== 32'd55) begin
            failures++;
            $display("FAIL stall_round: got rise=%0d len=%0d done=%0d status=%0d max=%0d want 22 1 26 0 55",
                     rise_cyc, start_cnt, done_cyc, d_status, d_max);
        end
    endtask

    task automatic test_round_only_timeout();
        set_req(1'b0, 32'hA5, 32'd0, 32'd0, 32'd0, 3'b000, 32'd0, 32'd0, 8'd4);
        stub(4'd0, 4'd0, -1, 32'd123, -1);
        run_req(60);
        checks++;
        if (n_ops != 0 || rise_cyc != 1 || start_cnt != 4 || fall_cyc != 5) begin
            failures++;
            $display("FAIL timeout_start: got n=%0d rise=%0d len=%0d fall=%0d want 0 1 4 5", n_ops, rise_cyc, start_cnt, fall_cyc);
        end
        checks++;
        if (done_cyc != fall_cyc + 16 || d_status !== 2'd2) begin
            failures++;
            $display("FAIL timeout_done: got cyc=%0d status=%0d want %0d 2", done_cyc, d_status, fall_cyc + 16);
        end
    endtask

    task automatic test_reset_mid_start();
        set_req(1'b0, 32'hA5, 32'd0, 32'd0, 32'd0, 3'b000, 32'd0, 32'd0, 8'd5);
        go = 1'b1;
        tick();
        go = 1'b0;
        checks++;
        if (C_start !== 1'b1) begin failures++; $display("FAIL rst_pre: got start=%0b want 1", C_start); end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (C_start !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: got start=%0b busy=%0b want 0 0", C_start, busy);
        end
        reset = 1'b0;
        tick();
        stub(4'd0, 4'd0, -1, 32'd0, -1);
        run_req(10);
        checks++;
        if (done_cyc != 1 || d_status !== 2'd1 || d_err !== 4'd0 || start_cnt != 0) begin
            failures++;
            $display("FAIL rst_unlocked_round: got cyc=%0d status=%0d err=%0d len=%0d want 1 1 0 0",
                     done_cyc, d_status, d_err, start_cnt);
        end
        set_req(1'b1, 32'h3C, 32'd4, 32'd5, 32'd6, 3'b010, 32'd2, 32'd3, 8'd1);
        stub(4'd0, 4'd0, 2, 32'd9, -1);
        run_req(60);
        checks++;
        if (n_ops != 7 || log_op[0] !== 4'd3 || log_cyc[0] != 1 || d_status !== 2'd0 || d_max !== 32'd9) begin
            failures++;
            $display("FAIL rst_reconfig: got n=%0d op0=%0d cyc0=%0d status=%0d max=%0d want 7 3 1 0 9",
                     n_ops, log_op[0], log_cyc[0], d_status, d_max);
        end
    endtask

    initial begin
        test_reset();
        test_first_config();
        test_relock_config();
        test_badkey();
        test_ready_stall();
        test_round_only_timeout();
        test_reset_mid_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
